alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width.
REQ-002 Parameter ALU_LAT, default 2: ALU settle time in clock cycles from operand drive to result capture; legal range 1..15.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req0_valid / req1_valid  input  1 each  requester N has an operation pending.
REQ-006 req0_ready / req1_ready  output  1 each  arbiter accepts requester N this cycle.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  WIDTH each  operands A and B of requester N.
REQ-008 req0_op / req1_op  input  4 each  ALU control code of requester N: 0010 add, 0110 subtract.
REQ-009 alu_a, alu_b  output  WIDTH each  operands driven to the shared ALU.
REQ-010 alu_ctrl  output  4  control code driven to the shared ALU.
REQ-011 alu_c  input  WIDTH  ALU result; alu_z  input  1  ALU zero/special flag.
REQ-012 rsp_valid  output  1  response held; rsp_ready  input  1  consumer takes response.
REQ-013 rsp_id  output  1  requester index owning the response.
REQ-014 rsp_c  output  WIDTH, rsp_z  output  1  captured ALU result and flag.
REQ-015 op_count  output  16  number of completed responses.

Function
REQ-016 FSM states: IDLE, EXEC, RESP; exactly one active at a time.
REQ-017 IDLE: grant computed combinationally from reqN_valid and round-robin pointer rr (last-served index); only one reqN_ready high per cycle, reqN_ready only in IDLE.
REQ-018 Single valid requester: that requester is granted regardless of rr.
REQ-019 Both valid: requester != rr is granted; rr updates to granted index on acceptance.
REQ-020 Acceptance = reqN_valid && reqN_ready at a rising edge; operands and op latched into alu_a, alu_b, alu_ctrl, owner index latched; FSM -> EXEC; cycle counter loaded with ALU_LAT-1.
REQ-021 EXEC: alu_a, alu_b, alu_ctrl held stable; counter decrements per cycle; at the edge where counter == 0, alu_c -> rsp_c, alu_z -> rsp_z, owner -> rsp_id, FSM -> RESP.
REQ-022 Latency: acceptance at edge k -> rsp_valid high after edge k+ALU_LAT.
REQ-023 RESP: rsp_valid = 1, rsp_c/rsp_z/rsp_id stable until rsp_valid && rsp_ready at an edge; then FSM -> IDLE, op_count increments.
REQ-024 No new acceptance during EXEC or RESP or in the RESP->IDLE handshake cycle; next acceptance earliest one cycle after the response handshake.
REQ-025 op_count wraps 0xFFFF -> 0x0000 without side effects.
REQ-026 alu_ctrl passes req op unchanged, including undefined codes; arbiter never alters operands.
REQ-027 reqN_valid dropping during EXEC/RESP has no effect on the in-flight operation.
REQ-028 rsp_ready high outside RESP is ignored.

Reset
REQ-029 rst_n low: FSM -> IDLE immediately, any in-flight operation discarded, no response produced.
REQ-030 Reset values: req0_ready=0 req1_ready=0 rsp_valid=0 rsp_id=0 rsp_c=0 rsp_z=0 alu_a=0 alu_b=0 alu_ctrl=0000 op_count=0, rr=1 (requester 0 wins first contention).
REQ-031 First acceptance possible in first cycle with rst_n high.

Verification
REQ-032 Single req0: a=5, b=3, op=0010, ALU_LAT=2, rsp_ready=1 -> req0_ready in cycle 0, rsp_valid after 2 edges, rsp_c=8, rsp_id=0, op_count=1.
REQ-033 Both valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1; op_count=4 after four responses.
REQ-034 req1 a=10 b=10 op=0110, rsp_ready=0 for 5 cycles -> rsp_valid held, rsp_c=0 and rsp_id=1 stable, no req ready asserted, op_count unchanged until rsp_ready=1.
REQ-035 Change req0_a from 7 to 9 during EXEC -> alu_a stays 7, rsp reflects 7.
REQ-036 rst_n low during EXEC -> all outputs at REQ-030 values same cycle, no rsp_valid afterwards without new request.
REQ-037 Preload 0xFFFF completions (or force) then one more -> op_count=0x0000.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared, multi-cycle ALU.
// Latency: acceptance at edge k gives rsp_valid high after edge k+ALU_LAT. The response is held until consumed.
// Backpressure: only one operation is in flight at a time. reqN_ready is low outside IDLE. rsp is held while rsp_ready is low.
//
// Ports:
//   clk, rst_n              clock; asynchronous active-low reset
//   reqN_valid/reqN_ready   requester N handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_op operands and 4-bit ALU control code of requester N
//   alu_a, alu_b, alu_ctrl  operands and control held stable on the shared ALU
//   alu_c, alu_z            ALU result and zero/special flag
//   rsp_valid/rsp_ready     response handshake
//   rsp_id, rsp_c, rsp_z    response owner, captured result and captured flag
//   op_count                completed-response counter; wraps at 16 bits
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 2    // legal range 1..15; sizes the 4-bit settle counter
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_z,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // The counter starts at ALU_LAT-1. Capture happens on the edge where it reads zero.
  // As a result, the ALU has exactly ALU_LAT edges to settle after the operands are driven.
  localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

  state_t           state_q,    state_d;
  logic             rr_q,       rr_d;
  logic [3:0]       cnt_q,      cnt_d;
  logic [WIDTH-1:0] alu_a_q,    alu_a_d;
  logic [WIDTH-1:0] alu_b_q,    alu_b_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;
  logic             owner_q,    owner_d;
  logic [WIDTH-1:0] rsp_c_q,    rsp_c_d;
  logic             rsp_z_q,    rsp_z_d;
  logic             rsp_id_q,   rsp_id_d;
  logic [15:0]      op_count_q, op_count_d;

  logic grant_vld;
  logic grant_id;

  // Grant selection. It is active only in IDLE.
  // If both requesters are valid, the one that was not served last wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (state_q == S_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = ~rr_q;
      end else if (req0_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  // Gate with rst_n so that ready stays low while reset is held, even if a requester is valid.
  assign req0_ready = rst_n && grant_vld && !grant_id;
  assign req1_ready = rst_n && grant_vld &&  grant_id;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_ctrl_d = alu_ctrl_q;
    owner_d    = owner_q;
    rsp_c_d    = rsp_c_q;
    rsp_z_d    = rsp_z_q;
    rsp_id_d   = rsp_id_q;
    op_count_d = op_count_q;

    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          // Operands and op code pass through untouched, including undefined codes.
          alu_a_d    = grant_id ? req1_a  : req0_a;
          alu_b_d    = grant_id ? req1_b  : req0_b;
          alu_ctrl_d = grant_id ? req1_op : req0_op;
          owner_d    = grant_id;
          rr_d       = grant_id;
          cnt_d      = CNT_LOAD;
          state_d    = S_EXEC;
        end
      end

      S_EXEC: begin
        if (cnt_q == 4'd0) begin
          rsp_c_d  = alu_c;
          rsp_z_d  = alu_z;
          rsp_id_d = owner_q;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_RESP: begin
        // The handshake cycle stays in RESP. Therefore no request can be accepted
        // until the cycle after the response is taken.
        if (rsp_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_q       <= 1'b1;    // requester 0 wins the first contention
      cnt_q      <= 4'd0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= 4'b0000;
      owner_q    <= 1'b0;
      rsp_c_q    <= '0;
      rsp_z_q    <= 1'b0;
      rsp_id_q   <= 1'b0;
      op_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctrl_q <= alu_ctrl_d;
      owner_q    <= owner_d;
      rsp_c_q    <= rsp_c_d;
      rsp_z_q    <= rsp_z_d;
      rsp_id_q   <= rsp_id_d;
      op_count_q <= op_count_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_z     = rsp_z_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with WIDTH=32 and ALU_LAT=2.
// The shared ALU is modelled here as add/subtract, with zero result for undefined codes.
// Inputs change and outputs are sampled around the falling edge, away from the rising edge.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [3:0]  alu_ctrl;
  logic        alu_z;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_z;
  logic [31:0] rsp_c;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.WIDTH(32), .ALU_LAT(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_c      (alu_c),
    .alu_z      (alu_z),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_c      (rsp_c),
    .rsp_z      (rsp_z),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU model
  always_comb begin
    alu_c = 32'd0;
    case (alu_ctrl)
      4'b0010: alu_c = alu_a + alu_b;
      4'b0110: alu_c = alu_a - alu_b;
      default: alu_c = 32'd0;
    endcase
    alu_z = (alu_c == 32'd0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one operation on an idle DUT with rsp_ready high.
  // It is entered and left on a falling edge.
  task automatic do_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [31:0] exp_c, input logic exp_z,
                       input logic [15:0] exp_cnt);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    #1;
    chk("op_grant", 64'({req1_ready, req0_ready}), 64'(id ? 2'b10 : 2'b01));
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("op_alu_a", 64'(alu_a), 64'(a));
    chk("op_alu_b", 64'(alu_b), 64'(b));
    chk("op_alu_ctrl", 64'(alu_ctrl), 64'(op));
    chk("op_exec_rsp_valid", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    chk("op_exec2_rsp_valid", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    chk("op_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("op_rsp_c", 64'(rsp_c), 64'(exp_c));
    chk("op_rsp_z", 64'(rsp_z), 64'(exp_z));
    chk("op_rsp_id", 64'(rsp_id), 64'(id));
    @(negedge clk);
    chk("op_done_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("op_count", 64'(op_count), 64'(exp_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'd0; req0_b = 32'd0; req0_op = 4'd0;
    req1_a = 32'd0; req1_b = 32'd0; req1_op = 4'd0;
    rsp_ready = 1'b1;

    // Reset values: check them with both requesters valid to prove that ready stays low.
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_ready", 64'({req1_ready, req0_ready}), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_id", 64'(rsp_id), 64'(0));
    chk("rst_rsp_c", 64'(rsp_c), 64'(0));
    chk("rst_rsp_z", 64'(rsp_z), 64'(0));
    chk("rst_alu_a", 64'(alu_a), 64'(0));
    chk("rst_alu_b", 64'(alu_b), 64'(0));
    chk("rst_alu_ctrl", 64'(alu_ctrl), 64'(0));
    chk("rst_op_count", 64'(op_count), 64'(0));
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Single req0 with 5+3, accepted in the first cycle out of reset.
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 32'd5, 32'd3, 4'b0010, 32'd8, 1'b0, 16'd1);

    // Reset asserted during EXEC: everything returns to reset values immediately.
    req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd1; req1_op = 4'b0110;
    #1;
    chk("rx_grant1", 64'(req1_ready), 64'(1));
    @(negedge clk);
    chk("rx_exec_alu_a", 64'(alu_a), 64'(4));
    rst_n = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("rx_alu_a", 64'(alu_a), 64'(0));
    chk("rx_alu_b", 64'(alu_b), 64'(0));
    chk("rx_alu_ctrl", 64'(alu_ctrl), 64'(0));
    chk("rx_rsp_c", 64'(rsp_c), 64'(0));
    chk("rx_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rx_op_count", 64'(op_count), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rx_no_rsp_after", 64'(rsp_valid), 64'(0));
    chk("rx_no_ready_after", 64'({req1_ready, req0_ready}), 64'(0));

    // Both requesters valid continuously after reset: grants alternate 0,1,0,1.
    req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd2; req0_op = 4'b0010;
    req1_valid = 1'b1; req1_a = 32'd20; req1_b = 32'd5; req1_op = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready0", 64'(req0_ready), 64'(i % 2 == 0));
      chk("rr_ready1", 64'(req1_ready), 64'(i % 2 == 1));
      @(negedge clk);
      @(negedge clk);
      chk("rr_lat_rsp_valid", 64'(rsp_valid), 64'(0));
      @(negedge clk);
      chk("rr_rsp_valid", 64'(rsp_valid), 64'(1));
      chk("rr_rsp_id", 64'(rsp_id), 64'(i % 2));
      chk("rr_rsp_c", 64'(rsp_c), 64'((i % 2 == 1) ? 15 : 3));
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("rr_op_count", 64'(op_count), 64'(4));

    // req1 10-10 with the consumer stalled for five cycles.
    // req1 was served last, but it is the sole requester, so it must still be granted.
    req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd10; req1_op = 4'b0110;
    rsp_ready = 1'b0;
    #1;
    chk("bp_grant", 64'({req1_ready, req0_ready}), 64'(2'b10));
    @(negedge clk);
    req0_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
      chk("bp_rsp_c", 64'(rsp_c), 64'(0));
      chk("bp_rsp_z", 64'(rsp_z), 64'(1));
      chk("bp_rsp_id", 64'(rsp_id), 64'(1));
      chk("bp_no_ready", 64'({req1_ready, req0_ready}), 64'(0));
      chk("bp_op_count", 64'(op_count), 64'(4));
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_hs_no_ready", 64'({req1_ready, req0_ready}), 64'(0));
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("bp_done_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("bp_op_count_inc", 64'(op_count), 64'(5));

    // Operand changes during EXEC do not disturb the in-flight operation.
    req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd1; req0_op = 4'b0010;
    #1;
    chk("hold_grant", 64'({req1_ready, req0_ready}), 64'(2'b01));
    @(negedge clk);
    req0_a = 32'd9;
    req0_valid = 1'b0;
    #1;
    chk("hold_alu_a", 64'(alu_a), 64'(7));
    @(negedge clk);
    chk("hold_alu_a2", 64'(alu_a), 64'(7));
    @(negedge clk);
    chk("hold_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("hold_rsp_c", 64'(rsp_c), 64'(8));
    @(negedge clk);
    chk("hold_op_count", 64'(op_count), 64'(6));

    // Undefined control code passes unchanged. Also check a 32-bit add that wraps to zero.
    do_op(1'b1, 32'd3, 32'd3, 4'b1111, 32'd0, 1'b1, 16'd7);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd0, 1'b1, 16'd8);

    // Counter wrap: preload 0xFFFF while idle, then complete one more operation.
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_q;
    #1;
    chk("wrap_preload", 64'(op_count), 64'(16'hFFFF));
    do_op(1'b1, 32'd100, 32'd1, 4'b0110, 32'd99, 1'b0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
